// File: rtl/adc_serial_responder.sv
// Conv/MISO slave: arms after NEED_LOW conv-low edges, shifts WIDTH bits MSB-first from P2 of the frame.
// A word latched at frame entry reaches MISO three posedges later; no valid at latch resends the old word (stale).
module adc_serial_responder #(
  parameter int   WIDTH      = 12,
  parameter logic IDLE_LEVEL = 1'b0,
  parameter int   NEED_LOW   = 2
) (
  input  logic             ADC_sclk,
  input  logic             reset,
  input  logic             ADC_MOSI,
  output logic             ADC_MISO,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             stale,
  output logic             frame_done,
  output logic [7:0]       frame_cnt
);

  localparam int LW = $clog2(NEED_LOW + 1);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [LW-1:0] LOW_SAT = LW'(NEED_LOW);
  localparam logic [LW-1:0] LOW_ONE = LW'(1);
  localparam logic [BW-1:0] BIT_TOP = BW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOW, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [LW-1:0]    lowcnt;
  logic [BW-1:0]    bitcnt;
  logic             conv_low;
  logic             latch_now;

  assign conv_low  = ~ADC_MOSI;
  // Every state except LOW enters LOW on conv low, so exactly one latch per low run.
  assign latch_now = conv_low && (state != LOW);

  always_ff @(posedge ADC_sclk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      shreg        <= '0;
      lowcnt       <= '0;
      bitcnt       <= '0;
      ADC_MISO     <= IDLE_LEVEL;
      sample_ready <= 1'b0;
      stale        <= 1'b0;
      frame_done   <= 1'b0;
      frame_cnt    <= 8'd0;
    end else begin
      sample_ready <= 1'b0;
      frame_done   <= 1'b0;

      if (latch_now) begin
        if (sample_valid) begin
          shreg        <= sample_in;
          sample_ready <= 1'b1;
          stale        <= 1'b0;
        end else begin
          stale <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (conv_low) begin
            state  <= LOW;
            lowcnt <= LOW_ONE;
          end
        end
        LOW: begin
          if (conv_low) begin
            if (lowcnt < LOW_SAT) lowcnt <= lowcnt + 1'b1;
          end else if (lowcnt >= LOW_SAT) begin
            state  <= SHIFT;
            bitcnt <= BIT_TOP;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          if (conv_low) begin
            ADC_MISO <= IDLE_LEVEL;
            state    <= LOW;
            lowcnt   <= LOW_ONE;
          end else begin
            ADC_MISO <= shreg[bitcnt];
            if (bitcnt == '0) state <= DONE;
            else              bitcnt <= bitcnt - 1'b1;
          end
        end
        DONE: begin
          ADC_MISO   <= IDLE_LEVEL;
          frame_done <= 1'b1;
          frame_cnt  <= frame_cnt + 8'd1;
          if (conv_low) begin
            state  <= LOW;
            lowcnt <= LOW_ONE;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_serial_responder.sv
// Directed bench: plays the capture-block master, one 16-posedge frame per run_frame call.
module tb_adc_serial_responder;

  logic        ADC_sclk = 1'b0;
  logic        reset = 1'b0;
  logic        ADC_MOSI = 1'b1;
  logic        ADC_MISO;
  logic [11:0] sample_in = 12'h000;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        stale;
  logic        frame_done;
  logic [7:0]  frame_cnt;

  int total = 0;
  int bad = 0;

  logic [11:0] got_code;
  int          n_done;
  int          n_ready;
  int          done_k;
  logic        miso_at [16];

  localparam logic [15:0] NORMAL = 16'h7FFE;

  adc_serial_responder #(.WIDTH(12), .IDLE_LEVEL(1'b0), .NEED_LOW(2)) dut (
    .ADC_sclk(ADC_sclk),
    .reset(reset),
    .ADC_MOSI(ADC_MOSI),
    .ADC_MISO(ADC_MISO),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .stale(stale),
    .frame_done(frame_done),
    .frame_cnt(frame_cnt)
  );

  always #5 ADC_sclk = ~ADC_sclk;

  // pat[k] is the conv level seen at posedge Pk; MISO captured after P2..P13.
  task automatic run_frame(input logic [15:0] pat);
    got_code = 12'h000;
    n_done   = 0;
    n_ready  = 0;
    done_k   = -1;
    for (int k = 0; k < 16; k++) begin
      @(negedge ADC_sclk);
      ADC_MOSI = pat[k];
      @(posedge ADC_sclk);
      #1;
      miso_at[k] = ADC_MISO;
      if (k >= 2 && k <= 13) got_code = {got_code[10:0], ADC_MISO};
      if (frame_done === 1'b1) begin
        n_done++;
        done_k = k;
      end
      if (sample_ready === 1'b1) n_ready++;
    end
  endtask

  task automatic test_reset;
    ADC_MOSI = 1'b1;
    #1 reset = 1'b1;
    #1;
    total++;
    if ({ADC_MISO, sample_ready, stale, frame_done, frame_cnt} !== 12'h000) begin
      bad++;
      $display("FAIL reset_state got=%h want=000", {ADC_MISO, sample_ready, stale, frame_done, frame_cnt});
    end
    repeat (2) @(posedge ADC_sclk);
    @(negedge ADC_sclk);
    reset = 1'b0;
  endtask

  task automatic test_first_frame;
    sample_in    = 12'hA5C;
    sample_valid = 1'b1;
    run_frame(NORMAL);
    total++;
    if (got_code !== 12'h000 || n_done != 0 || frame_cnt !== 8'd0) begin
      bad++;
      $display("FAIL first_frame_unarmed got code=%h done=%0d cnt=%0d want code=000 done=0 cnt=0", got_code, n_done, frame_cnt);
    end
    total++;
    if (n_ready != 2) begin
      bad++;
      $display("FAIL first_frame_ready got=%0d want=2", n_ready);
    end
    sample_in = 12'h123;
    run_frame(NORMAL);
    total++;
    if (got_code !== 12'hA5C) begin
      bad++;
      $display("FAIL frame2_code got=%h want=a5c", got_code);
    end
    total++;
    if (n_done != 1 || done_k != 14 || frame_cnt !== 8'd1) begin
      bad++;
      $display("FAIL frame2_done got n=%0d k=%0d cnt=%0d want n=1 k=14 cnt=1", n_done, done_k, frame_cnt);
    end
  endtask

  task automatic test_stale;
    sample_valid = 1'b0;
    run_frame(NORMAL);
    total++;
    if (got_code !== 12'h123) begin
      bad++;
      $display("FAIL stale_send_code got=%h want=123", got_code);
    end
    total++;
    if (stale !== 1'b1 || n_ready != 0) begin
      bad++;
      $display("FAIL stale_flag got stale=%b ready=%0d want stale=1 ready=0", stale, n_ready);
    end
    sample_valid = 1'b1;
    sample_in    = 12'hFFF;
    run_frame(NORMAL);
    total++;
    if (got_code !== 12'h123) begin
      bad++;
      $display("FAIL stale_resend_code got=%h want=123", got_code);
    end
    total++;
    if (stale !== 1'b0 || n_ready != 1) begin
      bad++;
      $display("FAIL stale_clear got stale=%b ready=%0d want stale=0 ready=1", stale, n_ready);
    end
    run_frame(NORMAL);
    total++;
    if (got_code !== 12'hFFF || frame_cnt !== 8'd4) begin
      bad++;
      $display("FAIL fresh_fff got code=%h cnt=%0d want code=fff cnt=4", got_code, frame_cnt);
    end
  endtask

  task automatic test_abort;
    sample_in = 12'h3C5;
    run_frame(16'h007E);
    total++;
    if (miso_at[6] !== 1'b1 || miso_at[7] !== 1'b0) begin
      bad++;
      $display("FAIL abort_miso got P6=%b P7=%b want P6=1 P7=0", miso_at[6], miso_at[7]);
    end
    total++;
    if (n_done != 0 || frame_cnt !== 8'd4) begin
      bad++;
      $display("FAIL abort_no_done got done=%0d cnt=%0d want done=0 cnt=4", n_done, frame_cnt);
    end
    total++;
    if (n_ready != 1) begin
      bad++;
      $display("FAIL abort_single_latch got=%0d want=1", n_ready);
    end
    sample_in = 12'h456;
    run_frame(NORMAL);
    total++;
    if (got_code !== 12'h3C5 || n_done != 1 || frame_cnt !== 8'd5) begin
      bad++;
      $display("FAIL post_abort got code=%h done=%0d cnt=%0d want code=3c5 done=1 cnt=5", got_code, n_done, frame_cnt);
    end
  endtask

  task automatic test_glitch;
    run_frame(16'h7FDF);
    total++;
    if (got_code !== 12'h000 || n_done != 0 || frame_cnt !== 8'd5) begin
      bad++;
      $display("FAIL glitch_no_frame got code=%h done=%0d cnt=%0d want code=000 done=0 cnt=5", got_code, n_done, frame_cnt);
    end
    total++;
    if (n_ready != 2) begin
      bad++;
      $display("FAIL glitch_latches got=%0d want=2", n_ready);
    end
    run_frame(NORMAL);
    total++;
    if (got_code !== 12'h456 || frame_cnt !== 8'd6) begin
      bad++;
      $display("FAIL post_glitch got code=%h cnt=%0d want code=456 cnt=6", got_code, frame_cnt);
    end
  endtask

  task automatic test_wrap;
    logic [7:0] exp_cnt;
    bit         saw_wrap;
    exp_cnt   = 8'd6;
    saw_wrap  = 1'b0;
    sample_in = 12'h5A3;
    for (int i = 0; i < 256; i++) begin
      run_frame(NORMAL);
      exp_cnt = exp_cnt + 8'd1;
      total++;
      if (n_done != 1 || done_k != 14 || frame_cnt !== exp_cnt) begin
        bad++;
        $display("FAIL wrap_frame%0d got done=%0d k=%0d cnt=%0d want done=1 k=14 cnt=%0d", i, n_done, done_k, frame_cnt, exp_cnt);
      end
      if (frame_cnt === 8'd0) saw_wrap = 1'b1;
    end
    total++;
    if (!saw_wrap || frame_cnt !== 8'd6) begin
      bad++;
      $display("FAIL wrap_result got wrap=%0d cnt=%0d want wrap=1 cnt=6", saw_wrap, frame_cnt);
    end
    total++;
    if (got_code !== 12'h5A3) begin
      bad++;
      $display("FAIL wrap_code got=%h want=5a3", got_code);
    end
  endtask

  task automatic test_reset_mid_shift;
    sample_in = 12'h7E7;
    run_frame(NORMAL);
    for (int k = 0; k <= 8; k++) begin
      @(negedge ADC_sclk);
      ADC_MOSI = NORMAL[k];
      @(posedge ADC_sclk);
      #1;
    end
    total++;
    if (ADC_MISO !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_bit got=%b want=1", ADC_MISO);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({ADC_MISO, sample_ready, stale, frame_done, frame_cnt} !== 12'h000) begin
      bad++;
      $display("FAIL mid_reset_state got=%h want=000", {ADC_MISO, sample_ready, stale, frame_done, frame_cnt});
    end
    @(negedge ADC_sclk);
    ADC_MOSI = 1'b1;
    repeat (2) @(posedge ADC_sclk);
    @(negedge ADC_sclk);
    reset = 1'b0;
    run_frame(NORMAL);
    total++;
    if (got_code !== 12'h000 || n_done != 0 || frame_cnt !== 8'd0) begin
      bad++;
      $display("FAIL post_reset_unarmed got code=%h done=%0d cnt=%0d want code=000 done=0 cnt=0", got_code, n_done, frame_cnt);
    end
    run_frame(NORMAL);
    total++;
    if (got_code !== 12'h7E7 || n_done != 1 || frame_cnt !== 8'd1) begin
      bad++;
      $display("FAIL post_reset_frame got code=%h done=%0d cnt=%0d want code=7e7 done=1 cnt=1", got_code, n_done, frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_stale();
    test_abort();
    test_glitch();
    test_wrap();
    test_reset_mid_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
